// File: rtl/memory_responder.sv
// memory_responder: unified instruction/data memory port for a multicycle RV32I core.
// Latency: read data registered, 1 cycle; stores and LED writes commit at the sampling posedge.
// Backpressure: none, every cycle is an access; optional timers built when MEMRESP_TIMER_EN is defined.
module memory_responder #(
  parameter int MEM_WORDS = 2048,
  parameter int CLK_HZ    = 12000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] wd,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  output logic [31:0] rd,
  output logic [2:0]  led,
  output logic        misalign
);

  localparam int AW = $clog2(MEM_WORDS);

  // MMIO word addresses (byte address >> 2)
  localparam logic [29:0] LED_WA = 30'h3FFF_FFFF;  // 0xFFFF_FFFC
  localparam logic [29:0] MS_WA  = 30'h3FFF_FFFE;  // 0xFFFF_FFF8
  localparam logic [29:0] US_WA  = 30'h3FFF_FFFD;  // 0xFFFF_FFF4

  logic [31:0]   r_mem [MEM_WORDS];
  logic [31:0]   r_rd;
  logic [2:0]    r_led;
  logic          r_misalign;

  logic          w_is_half;
  logic          w_is_word;
  logic          w_misalign;
  logic          w_is_ram;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdat;
  logic          w_we_ram;
  logic          w_we_led;
  logic [31:0]   w_word;
  logic [31:0]   w_lane;
  logic [31:0]   w_rdat;
  logic [31:0]   w_us;
  logic [31:0]   w_ms;

  assign w_is_half  = (funct3[1:0] == 2'b01);
  assign w_is_word  = funct3[1];
  assign w_misalign = (w_is_half & adr[0]) | (w_is_word & (adr[1:0] != 2'b00));
  assign w_is_ram   = ~adr[31];
  assign w_idx      = adr[AW+1:2];
  assign w_we_ram   = memwrite & w_is_ram & ~w_misalign & ~rst;
  assign w_we_led   = memwrite & (adr[31:2] == LED_WA) & ~w_misalign & w_be[0];

  // Byte-lane enables and lane-replicated store data from size and offset
  always_comb begin
    w_be   = 4'b0000;
    w_wdat = wd;
    case (funct3[1:0])
      2'b00: begin
        w_be   = 4'b0001 << adr[1:0];
        w_wdat = {4{wd[7:0]}};
      end
      2'b01: begin
        w_be   = adr[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{wd[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_wdat = wd;
      end
    endcase
  end

  // Source word: RAM (aliased by index width) or the MMIO window
  always_comb begin
    w_word = 32'h0;
    if (w_is_ram) begin
      w_word = r_mem[w_idx];
    end else begin
      case (adr[31:2])
        LED_WA:  w_word = {29'h0, r_led};
        MS_WA:   w_word = w_ms;
        US_WA:   w_word = w_us;
        default: w_word = 32'h0;
      endcase
    end
  end

  // Shift the addressed byte/half down to bit 0 and extend
  always_comb begin
    w_lane = w_word >> {adr[1:0], 3'b000};
    w_rdat = w_word;
    case (funct3[1:0])
      2'b00:   w_rdat = funct3[2] ? {24'h0, w_lane[7:0]}
                                  : {{24{w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_rdat = funct3[2] ? {16'h0, w_lane[15:0]}
                                  : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_rdat = w_word;
    endcase
  end

  // RAM byte-lane write; read above sees the pre-write contents this cycle
  always_ff @(posedge clk) begin
    if (w_we_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
        end
      end
    end
  end

  // Read data, LED register and sticky misalign flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd       <= 32'h0;
      r_led      <= 3'b000;
      r_misalign <= 1'b0;
    end else begin
      r_rd <= w_misalign ? 32'h0 : w_rdat;
      if (w_misalign) begin
        r_misalign <= 1'b1;
      end
      if (w_we_led) begin
        r_led <= w_wdat[2:0];
      end
    end
  end

`ifdef MEMRESP_TIMER_EN
  localparam logic [31:0] PRESC_LAST = 32'(CLK_HZ / 1000000 - 1);

  logic [31:0] r_presc;
  logic [9:0]  r_sub;
  logic [31:0] r_us;
  logic [31:0] r_ms;

  // Prescaler to microsecond ticks, then a 1000-tick divider to milliseconds
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= 32'h0;
      r_sub   <= 10'd0;
      r_us    <= 32'h0;
      r_ms    <= 32'h0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= 32'h0;
      r_us    <= r_us + 32'd1;
      if (r_sub == 10'd999) begin
        r_sub <= 10'd0;
        r_ms  <= r_ms + 32'd1;
      end else begin
        r_sub <= r_sub + 10'd1;
      end
    end else begin
      r_presc <= r_presc + 32'd1;
    end
  end

  assign w_us = r_us;
  assign w_ms = r_ms;
`else
  logic w_unused_clk_hz;
  assign w_unused_clk_hz = (CLK_HZ == 0);
  assign w_us = 32'h0;
  assign w_ms = 32'h0;
`endif

  assign rd       = r_rd;
  assign led      = r_led;
  assign misalign = r_misalign;

endmodule
